// File: rtl/program_sequencer.sv
// Program ROM walker: fetches 12-bit {op, bus, data, ack} instructions and executes them
// against the DAC and I2C byte engines, timing DELAY steps from the ROM delay table.
module program_sequencer #(
   parameter int unsigned PROG_LEN = 21,
   parameter logic [1:0]  OP_I2C   = 2'b00,
   parameter logic [1:0]  OP_DAC   = 2'b01,
   parameter logic [1:0]  OP_DELAY = 2'b10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [7:0]  instr_pt,
   input  logic [11:0] instr,
   output logic [7:0]  delay_num,
   input  logic [31:0] delay_len,
   output logic [7:0]  dac_data,
   output logic        dac_load,
   input  logic        dac_busy,
   output logic        i2c_req,
   output logic        i2c_bus,
   output logic [7:0]  i2c_data,
   input  logic        i2c_done,
   input  logic        i2c_nak,
   output logic        running,
   output logic        done,
   output logic        fault,
   output logic [7:0]  fault_pt
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_EXEC, S_WAIT_DLY, S_WAIT_I2C, S_DONE, S_FAULT
   } state_t;

   state_t      state, state_n;
   logic [11:0] instr_q, instr_q_n;
   logic [31:0] cnt, cnt_n;
   logic [7:0]  pt_n, dac_data_n, i2c_data_n, fault_pt_n;
   logic        dac_load_n, i2c_req_n, i2c_bus_n;
   logic        running_n, done_n, fault_n;

   assign delay_num = instr_q[8:1];

   always_comb begin
      state_n    = state;
      pt_n       = instr_pt;
      instr_q_n  = instr_q;
      cnt_n      = cnt;
      dac_data_n = dac_data;
      dac_load_n = 1'b0;
      i2c_req_n  = i2c_req;
      i2c_bus_n  = i2c_bus;
      i2c_data_n = i2c_data;
      fault_pt_n = fault_pt;
      case (state)
         S_IDLE, S_DONE, S_FAULT: begin
            if (start) begin
               state_n    = S_FETCH;
               pt_n       = '0;
               fault_pt_n = '0;
            end
         end
         S_FETCH: begin
            if (instr_pt == 8'(PROG_LEN)) begin
               state_n = S_DONE;
            end else begin
               instr_q_n = instr;
               state_n   = S_EXEC;
            end
         end
         S_EXEC: begin
            if (instr_q[11:10] == OP_DELAY) begin
               cnt_n   = delay_len;
               state_n = S_WAIT_DLY;
            end else if (instr_q[11:10] == OP_DAC) begin
               if (!dac_busy) begin
                  dac_data_n = instr_q[8:1];
                  dac_load_n = 1'b1;
                  pt_n       = instr_pt + 8'd1;
                  state_n    = S_FETCH;
               end
            end else if (instr_q[11:10] == OP_I2C) begin
               i2c_req_n  = 1'b1;
               i2c_bus_n  = instr_q[9];
               i2c_data_n = instr_q[8:1];
               state_n    = S_WAIT_I2C;
            end else begin
               state_n = S_DONE;
            end
         end
         S_WAIT_DLY: begin
            if (cnt != '0) begin
               cnt_n = cnt - 32'd1;
            end else begin
               pt_n    = instr_pt + 8'd1;
               state_n = S_FETCH;
            end
         end
         S_WAIT_I2C: begin
            // The received ack bit must equal the expected ack stored in the instruction.
            if (i2c_done) begin
               i2c_req_n = 1'b0;
               if (i2c_nak == instr_q[0]) begin
                  pt_n    = instr_pt + 8'd1;
                  state_n = S_FETCH;
               end else begin
                  fault_pt_n = instr_pt;
                  state_n    = S_FAULT;
               end
            end
         end
         default: state_n = S_IDLE;
      endcase
      running_n = (state_n == S_FETCH) || (state_n == S_EXEC) ||
                  (state_n == S_WAIT_DLY) || (state_n == S_WAIT_I2C);
      done_n    = (state_n == S_DONE);
      fault_n   = (state_n == S_FAULT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         instr_pt <= '0;
         instr_q  <= '0;
         cnt      <= '0;
         dac_data <= '0;
         dac_load <= 1'b0;
         i2c_req  <= 1'b0;
         i2c_bus  <= 1'b0;
         i2c_data <= '0;
         fault_pt <= '0;
         running  <= 1'b0;
         done     <= 1'b0;
         fault    <= 1'b0;
      end else begin
         state    <= state_n;
         instr_pt <= pt_n;
         instr_q  <= instr_q_n;
         cnt      <= cnt_n;
         dac_data <= dac_data_n;
         dac_load <= dac_load_n;
         i2c_req  <= i2c_req_n;
         i2c_bus  <= i2c_bus_n;
         i2c_data <= i2c_data_n;
         fault_pt <= fault_pt_n;
         running  <= running_n;
         done     <= done_n;
         fault    <= fault_n;
      end
   end

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: a two-instruction ROM model, delay table and
// I2C responder, with per-scenario tasks checking cycle-exact behaviour.
module tb_program_sequencer;

   localparam logic [1:0] OP_I2C = 2'b00, OP_DAC = 2'b01, OP_DELAY = 2'b10, OP_HALT = 2'b11;

   logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [7:0]  instr_pt, delay_num, dac_data, i2c_data, fault_pt;
   logic [11:0] instr;
   logic [31:0] delay_len;
   logic        dac_load, dac_busy = 1'b0, i2c_req, i2c_bus;
   logic        i2c_done = 1'b0, i2c_nak = 1'b0, running, done, fault;

   logic [11:0] rom [0:255];
   logic [31:0] dly [0:255];

   assign instr     = rom[instr_pt];
   assign delay_len = dly[delay_num];

   always #5 clk = ~clk;

   program_sequencer #(.PROG_LEN(2)) dut (
      .clk(clk), .rst(rst), .start(start), .instr_pt(instr_pt), .instr(instr),
      .delay_num(delay_num), .delay_len(delay_len), .dac_data(dac_data),
      .dac_load(dac_load), .dac_busy(dac_busy), .i2c_req(i2c_req), .i2c_bus(i2c_bus),
      .i2c_data(i2c_data), .i2c_done(i2c_done), .i2c_nak(i2c_nak), .running(running),
      .done(done), .fault(fault), .fault_pt(fault_pt)
   );

   int errors = 0, checks = 0;

   // Observations gathered by run_prog, indexed by negedges after the start edge.
   int          t_run, t_pt1, t_pt2, t_done, t_fault, t_load, n_load, n_req, run_req;
   logic [7:0]  load_data, req_data, f1_pt, f1_fault_pt;
   logic        req_bus, req_unstable, f1_fault, f1_running;

   function automatic logic [11:0] enc(input logic [1:0] op, input logic bus,
                                       input logic [7:0] d, input logic ack);
      return {op, bus, d, ack};
   endfunction

   task automatic load2(input logic [11:0] a, input logic [11:0] b);
      rom[0] = a;
      rom[1] = b;
   endtask

   task automatic run_prog(input int budget, input int lat, input logic nak, input int poke);
      t_run = -1; t_pt1 = -1; t_pt2 = -1; t_done = -1; t_fault = -1; t_load = -1;
      n_load = 0; n_req = 0; run_req = 0; req_unstable = 1'b0;
      load_data = '0; req_data = '0; req_bus = 1'b0;
      @(negedge clk);
      start = 1'b1;
      for (int i = 1; i <= budget; i++) begin
         @(negedge clk);
         start = 1'b0; i2c_done = 1'b0; i2c_nak = 1'b0;
         if (i == 1) begin
            f1_fault = fault; f1_running = running; f1_pt = instr_pt; f1_fault_pt = fault_pt;
         end
         if (running && t_run < 0) t_run = i;
         if (instr_pt == 8'd1 && t_pt1 < 0) t_pt1 = i;
         if (instr_pt == 8'd2 && t_pt2 < 0) t_pt2 = i;
         if (dac_load) begin
            n_load++;
            if (t_load < 0) begin t_load = i; load_data = dac_data; end
         end
         if (i2c_req) begin
            n_req++; run_req++;
            if (n_req == 1) begin req_bus = i2c_bus; req_data = i2c_data; end
            else if (i2c_bus !== req_bus || i2c_data !== req_data) req_unstable = 1'b1;
            if (run_req == lat) begin i2c_done = 1'b1; i2c_nak = nak; end
         end else begin
            run_req = 0;
         end
         if (i == poke) begin start = 1'b1; i2c_done = 1'b1; i2c_nak = ~nak; end
         if (done) begin t_done = i; break; end
         if (fault) begin t_fault = i; break; end
      end
      i2c_done = 1'b0; start = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++; if ({running, done, fault, dac_load, i2c_req, i2c_bus, instr_pt, dac_data, i2c_data, fault_pt, delay_num} !== '0) begin errors++; $display("FAIL reset_outputs: got running=%b done=%b fault=%b pt=%0d dac=%h expected all zero", running, done, fault, instr_pt, dac_data); end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if ({running, done, fault} !== 3'b000) begin errors++; $display("FAIL idle_status: got %b expected 000", {running, done, fault}); end
   endtask

   task automatic test_dac_delay();
      load2(enc(OP_DAC, 1'b0, 8'h8E, 1'b0), enc(OP_DELAY, 1'b0, 8'd3, 1'b0));
      run_prog(100, 1, 1'b0, 0);
      checks++; if (t_run !== 1) begin errors++; $display("FAIL t1_start_fetch: got %0d expected 1", t_run); end
      checks++; if (n_load !== 1 || t_load !== 3) begin errors++; $display("FAIL t1_dac_load: got n=%0d at %0d expected n=1 at 3", n_load, t_load); end
      checks++; if (load_data !== 8'h8E) begin errors++; $display("FAIL t1_dac_data: got %h expected 8e", load_data); end
      checks++; if (t_pt2 - t_pt1 !== 30 || t_pt1 !== 3) begin errors++; $display("FAIL t1_delay_cycles: got %0d (pt1 at %0d) expected 30 (pt1 at 3)", t_pt2 - t_pt1, t_pt1); end
      checks++; if (t_done !== 34) begin errors++; $display("FAIL t1_done: got %0d expected 34", t_done); end
      checks++; if (instr_pt !== 8'd2 || delay_num !== 8'd3) begin errors++; $display("FAIL t1_final_pt: got pt=%0d dnum=%0d expected 2/3", instr_pt, delay_num); end
   endtask

   task automatic test_i2c_pass();
      load2(enc(OP_I2C, 1'b1, 8'h84, 1'b0), enc(OP_DAC, 1'b0, 8'h11, 1'b0));
      run_prog(100, 5, 1'b0, 0);
      checks++; if (n_req !== 5) begin errors++; $display("FAIL t2_req_len: got %0d expected 5", n_req); end
      checks++; if (req_bus !== 1'b1 || req_data !== 8'h84 || req_unstable !== 1'b0) begin errors++; $display("FAIL t2_req_fields: got bus=%b data=%h unstable=%b expected 1/84/0", req_bus, req_data, req_unstable); end
      checks++; if (t_pt1 !== 8) begin errors++; $display("FAIL t2_next_fetch: got %0d expected 8", t_pt1); end
      checks++; if (t_load !== 10 || load_data !== 8'h11) begin errors++; $display("FAIL t2_dac: got %0d/%h expected 10/11", t_load, load_data); end
      checks++; if (t_done !== 11 || fault !== 1'b0) begin errors++; $display("FAIL t2_done: got %0d fault=%b expected 11 fault=0", t_done, fault); end
   endtask

   task automatic test_halt();
      load2(enc(OP_HALT, 1'b0, 8'h00, 1'b0), enc(OP_DAC, 1'b0, 8'h77, 1'b0));
      run_prog(40, 1, 1'b0, 0);
      checks++; if (t_done !== 3 || instr_pt !== 8'd0 || n_load !== 0) begin errors++; $display("FAIL halt: got done@%0d pt=%0d loads=%0d expected 3/0/0", t_done, instr_pt, n_load); end
      checks++; if (dac_data !== 8'h11) begin errors++; $display("FAIL dac_persist: got %h expected 11", dac_data); end
   endtask

   task automatic test_i2c_fault();
      int bad;
      load2(enc(OP_DAC, 1'b0, 8'h22, 1'b0), enc(OP_I2C, 1'b0, 8'h3C, 1'b0));
      run_prog(100, 2, 1'b1, 0);
      checks++; if (t_fault !== 7 || fault_pt !== 8'd1) begin errors++; $display("FAIL t3_fault: got @%0d fault_pt=%0d expected @7 fault_pt=1", t_fault, fault_pt); end
      checks++; if (running !== 1'b0 || i2c_req !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL t3_status: got run=%b req=%b done=%b expected 000", running, i2c_req, done); end
      checks++; if (req_bus !== 1'b0 || req_data !== 8'h3C || n_req !== 2) begin errors++; $display("FAIL t3_req: got bus=%b data=%h n=%0d expected 0/3c/2", req_bus, req_data, n_req); end
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (instr_pt !== 8'd1 || running !== 1'b0 || fault !== 1'b1) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL t3_hold: got %0d bad cycles expected 0", bad); end
      run_prog(100, 2, 1'b0, 0);
      checks++; if (f1_fault !== 1'b0 || f1_pt !== 8'd0 || f1_running !== 1'b1 || f1_fault_pt !== 8'd0) begin errors++; $display("FAIL t3_restart: got fault=%b pt=%0d run=%b fpt=%0d expected 0/0/1/0", f1_fault, f1_pt, f1_running, f1_fault_pt); end
      checks++; if (t_done !== 8) begin errors++; $display("FAIL t3_rerun_done: got %0d expected 8", t_done); end
   endtask

   task automatic test_delay_edges();
      load2(enc(OP_DELAY, 1'b0, 8'd0, 1'b0), enc(OP_DELAY, 1'b0, 8'd5, 1'b0));
      run_prog(5200, 1, 1'b0, 100);
      checks++; if (t_pt1 - t_run !== 3) begin errors++; $display("FAIL delay_zero: got %0d expected 3", t_pt1 - t_run); end
      checks++; if (t_pt2 - t_pt1 !== 5003) begin errors++; $display("FAIL delay_long: got %0d expected 5003", t_pt2 - t_pt1); end
      checks++; if (t_done !== 5008 || delay_num !== 8'd5) begin errors++; $display("FAIL delay_done: got %0d dnum=%0d expected 5008/5", t_done, delay_num); end
   endtask

   task automatic test_dac_busy();
      int n, first_i, second_i, td;
      logic [7:0] first_d, second_d;
      n = 0; first_i = -1; second_i = -1; td = -1; first_d = '0; second_d = '0;
      load2(enc(OP_DAC, 1'b0, 8'h5A, 1'b1), enc(OP_DAC, 1'b1, 8'hA5, 1'b0));
      @(negedge clk);
      dac_busy = 1'b1; start = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (dac_load) begin
            n++;
            if (n == 1) begin first_i = i; first_d = dac_data; end
            else begin second_i = i; second_d = dac_data; end
         end
         if (done && td < 0) td = i;
         dac_busy = (i < 6);
      end
      dac_busy = 1'b0;
      checks++; if (n !== 2 || first_i !== 7 || first_d !== 8'h5A) begin errors++; $display("FAIL busy_first_load: got n=%0d @%0d data=%h expected 2 @7 5a", n, first_i, first_d); end
      checks++; if (second_i !== 9 || second_d !== 8'hA5 || td !== 10) begin errors++; $display("FAIL busy_second_load: got @%0d %h done@%0d expected @9 a5 done@10", second_i, second_d, td); end
   endtask

   task automatic test_reset_mid();
      int waited;
      load2(enc(OP_DELAY, 1'b0, 8'd3, 1'b0), enc(OP_I2C, 1'b1, 8'h84, 1'b1));
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (10) @(negedge clk);
      checks++; if (running !== 1'b1) begin errors++; $display("FAIL mid_dly_running: got %b expected 1", running); end
      #2 rst = 1'b1;
      #1;
      checks++; if ({running, done, fault, dac_load, i2c_req, i2c_bus, instr_pt, dac_data, i2c_data, fault_pt, delay_num} !== '0) begin errors++; $display("FAIL rst_in_dly: got run=%b pt=%0d dac=%h dnum=%0d expected all zero", running, instr_pt, dac_data, delay_num); end
      @(negedge clk); rst = 1'b0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      waited = 0;
      while (!i2c_req && waited < 100) begin @(negedge clk); waited++; end
      checks++; if (i2c_req !== 1'b1) begin errors++; $display("FAIL wait_i2c_req: got timeout after %0d cycles expected req", waited); end
      #2 rst = 1'b1;
      #1;
      checks++; if ({running, dac_load, i2c_req, i2c_bus, i2c_data, instr_pt} !== '0) begin errors++; $display("FAIL rst_in_i2c: got run=%b req=%b bus=%b data=%h pt=%0d expected all zero", running, i2c_req, i2c_bus, i2c_data, instr_pt); end
      @(negedge clk); rst = 1'b0;
      run_prog(100, 3, 1'b1, 0);
      checks++; if (t_run !== 1 || t_pt1 !== 31 || n_req !== 3) begin errors++; $display("FAIL rerun_timing: got run@%0d pt1@%0d req=%0d expected 1/31/3", t_run, t_pt1, n_req); end
      checks++; if (t_pt2 !== 36 || t_done !== 37 || fault !== 1'b0) begin errors++; $display("FAIL rerun_done: got pt2@%0d done@%0d fault=%b expected 36/37/0", t_pt2, t_done, fault); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         rom[i] = enc(OP_HALT, 1'b0, 8'h00, 1'b0);
         dly[i] = 32'd1;
      end
      dly[0] = 32'd0;
      dly[3] = 32'd27;
      dly[5] = 32'd5000;
      test_reset();
      test_dac_delay();
      test_i2c_pass();
      test_halt();
      test_i2c_fault();
      test_delay_edges();
      test_dac_busy();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
